// File: rtl/sort_arb.sv
// sort_arb: two-requester front end for a streaming sorter core.
// A requester is granted round-robin and its ELEMENT_NUM elements are staged
// locally. They are then burst into the sorter, and the sorted stream is passed
// straight through to the result port.
// Optional feature macro: SORT_ARB_PREFETCH_EN. When it is defined, the next
// job is collected while the current job is sorting and draining.
module sort_arb #(
  parameter int DATA_WIDTH       = 8,
  parameter int ELEMENT_NUM      = 16,
  parameter int LOG2_ELEMENT_NUM = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  srt_rst,
  output logic                  srt_um_valid,
  output logic [DATA_WIDTH-1:0] srt_um_data,
  input  logic                  srt_sm_valid,
  input  logic [DATA_WIDTH-1:0] srt_sm_data,
  input  logic                  srt_done,
  output logic                  res_valid,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_id,
  output logic                  res_last,
  output logic                  busy
);

  localparam int CW = LOG2_ELEMENT_NUM + 1;
  localparam logic [CW-1:0] LAST = CW'(ELEMENT_NUM - 1);
  localparam logic [CW-1:0] FULL = CW'(ELEMENT_NUM);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_BURST,
    S_SORT,
    S_DRAIN
`ifdef SORT_ARB_PREFETCH_EN
    , S_RELOAD
`endif
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_grant;       // owner of the job in flight
  logic                  r_last_served; // round-robin memory: 1 means req0 wins a tie
  logic [CW-1:0]         r_ld_cnt;
  logic [CW-1:0]         r_dr_cnt;
  logic [DATA_WIDTH-1:0] r_buf [ELEMENT_NUM];

  logic                  w_any;
  logic                  w_pick;
  logic                  w_ld_en;
  logic                  w_ld_sel;
  logic                  w_acc;
  logic [DATA_WIDTH-1:0] w_acc_data;
  logic                  w_res_valid;
  logic                  w_res_last;

  // Arbitration: a lone requester wins; on a tie the one not served last wins.
  assign w_any  = req0_valid | req1_valid;
  assign w_pick = (req0_valid & req1_valid) ? ~r_last_served : req1_valid;

`ifdef SORT_ARB_PREFETCH_EN
  logic r_pf_act;
  logic r_pf_grant;
  logic w_pf_phase;
  logic w_pf_grant;
  logic w_pf_full;

  assign w_pf_phase = (r_state == S_SORT) || (r_state == S_DRAIN);
  assign w_pf_grant = w_pf_phase & ~r_pf_act & w_any & ~w_res_last;
  assign w_ld_en    = (r_state == S_COLLECT) ||
                      (w_pf_phase && r_pf_act && (r_ld_cnt != FULL));
  assign w_ld_sel   = w_pf_phase ? r_pf_grant : r_grant;
  assign w_pf_full  = (r_ld_cnt == FULL) || (w_acc && (r_ld_cnt == LAST));

  // Prefetch grant: claimed once during SORT/DRAIN, released when DRAIN ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pf_act   <= 1'b0;
      r_pf_grant <= 1'b0;
    end else if (w_pf_grant) begin
      r_pf_act   <= 1'b1;
      r_pf_grant <= w_pick;
    end else if (r_state == S_DRAIN && w_next != S_DRAIN) begin
      r_pf_act   <= 1'b0;
    end
  end
`else
  assign w_ld_en  = (r_state == S_COLLECT);
  assign w_ld_sel = r_grant;
`endif

  assign req0_ready = w_ld_en & ~w_ld_sel;
  assign req1_ready = w_ld_en &  w_ld_sel;
  assign w_acc      = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign w_acc_data = w_ld_sel ? req1_data : req0_data;

  assign w_res_valid = (r_state == S_DRAIN) & srt_sm_valid & ~srt_done;
  assign w_res_last  = w_res_valid & (r_dr_cnt == LAST);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decision.
  // NOTE: w_next gets a default before the case so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (w_any) w_next = S_COLLECT;
      S_COLLECT: if (w_acc && r_ld_cnt == LAST) w_next = S_BURST;
      S_BURST:   if (r_ld_cnt == LAST) w_next = S_SORT;
      S_SORT:    if (srt_sm_valid) w_next = S_DRAIN;
      S_DRAIN: begin
        if (w_res_last) begin
`ifdef SORT_ARB_PREFETCH_EN
          if (!r_pf_act)      w_next = S_IDLE;
          else if (w_pf_full) w_next = S_RELOAD;
          else                w_next = S_COLLECT;
`else
          w_next = S_IDLE;
`endif
        end
      end
`ifdef SORT_ARB_PREFETCH_EN
      S_RELOAD:  w_next = S_BURST;
`endif
      default:   w_next = S_IDLE;
    endcase
  end

  // Job ownership and round-robin memory, updated whenever a grant is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant       <= 1'b0;
      r_last_served <= 1'b1;
    end else if (r_state == S_IDLE && w_any) begin
      r_grant       <= w_pick;
      r_last_served <= w_pick;
    end
`ifdef SORT_ARB_PREFETCH_EN
    else begin
      if (w_pf_grant) r_last_served <= w_pick;
      if (r_state == S_DRAIN && w_next != S_DRAIN && r_pf_act) r_grant <= r_pf_grant;
    end
`endif
  end

  // Load counter: indexes the staging buffer for both collect and burst.
  // Collection begun during SORT/DRAIN carries over into the following state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ld_cnt <= '0;
    end else if (r_state == S_BURST && w_next == S_BURST) begin
      r_ld_cnt <= r_ld_cnt + 1'b1;
    end else if (w_next != r_state &&
                 !((r_state == S_SORT || r_state == S_DRAIN) && w_next != S_IDLE)) begin
      r_ld_cnt <= '0;
    end else if (w_acc) begin
      r_ld_cnt <= r_ld_cnt + 1'b1;
    end
  end

  // Drain counter: counts result beats within DRAIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_dr_cnt <= '0;
    else if (w_next != r_state) r_dr_cnt <= '0;
    else if (w_res_valid)       r_dr_cnt <= r_dr_cnt + 1'b1;
  end

  // Staging buffer write.
  // NOTE: the buffer has no reset; its contents only matter after being written.
  always_ff @(posedge clk) begin
    if (w_acc) r_buf[r_ld_cnt[LOG2_ELEMENT_NUM-1:0]] <= w_acc_data;
  end

  // Sorter-side and result-side outputs, all decoded from the current state.
  always_comb begin
    srt_rst      = (r_state == S_IDLE) || (r_state == S_COLLECT);
`ifdef SORT_ARB_PREFETCH_EN
    if (r_state == S_RELOAD) srt_rst = 1'b1;
`endif
    srt_um_valid = (r_state == S_BURST);
    srt_um_data  = srt_um_valid ? r_buf[r_ld_cnt[LOG2_ELEMENT_NUM-1:0]] : '0;
    res_valid    = w_res_valid;
    res_data     = (r_state == S_DRAIN) ? srt_sm_data : '0;
    res_id       = (r_state == S_DRAIN) & r_grant;
    res_last     = w_res_last;
    busy         = (r_state != S_IDLE);
  end

endmodule

// File: tb/tb_sort_arb.sv
// tb_sort_arb: directed bench for sort_arb with a behavioural sorter core.
module tb_sort_arb;

  typedef logic [7:0] vec_t [16];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic       req0_ready, req1_ready;
  logic       srt_rst, srt_um_valid;
  logic [7:0] srt_um_data;
  logic       srt_sm_valid, srt_done;
  logic [7:0] srt_sm_data;
  logic       res_valid, res_id, res_last, busy;
  logic [7:0] res_data;

  int n_vec = 0;
  int n_err = 0;

  vec_t v_a = '{8'd5, 8'd3, 8'd9, 8'd1, 8'd14, 8'd7, 8'd0, 8'd12,
                8'd8, 8'd2, 8'd15, 8'd6, 8'd11, 8'd4, 8'd13, 8'd10};
  vec_t s_a = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7,
                8'd8, 8'd9, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15};
  vec_t v_b = '{8'd200, 8'd17, 8'd99, 8'd17, 8'd255, 8'd0, 8'd64, 8'd128,
                8'd33, 8'd1, 8'd250, 8'd80, 8'd99, 8'd5, 8'd42, 8'd7};
  vec_t s_b = '{8'd0, 8'd1, 8'd5, 8'd7, 8'd17, 8'd17, 8'd33, 8'd42,
                8'd64, 8'd80, 8'd99, 8'd99, 8'd128, 8'd200, 8'd250, 8'd255};
  vec_t v_f = '{default: 8'hFF};

`ifdef SORT_ARB_PREFETCH_EN
  localparam bit EXP_RDY_DRAIN = 1'b1;
  localparam int EXP_GAP       = 2;
`else
  localparam bit EXP_RDY_DRAIN = 1'b0;
  localparam int EXP_GAP       = 18;
`endif

  sort_arb #(.DATA_WIDTH(8), .ELEMENT_NUM(16), .LOG2_ELEMENT_NUM(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .srt_rst(srt_rst), .srt_um_valid(srt_um_valid), .srt_um_data(srt_um_data),
    .srt_sm_valid(srt_sm_valid), .srt_sm_data(srt_sm_data), .srt_done(srt_done),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
    .res_last(res_last), .busy(busy)
  );

  always #5 clk = ~clk;

  // Sorter model: loads 16 words, waits, raises valid holding its first word
  // for one extra cycle, streams the ascending result, then raises done.
  logic [7:0] m_mem [16];
  int m_ld, m_dly, m_idx;
  initial begin
    srt_sm_valid = 1'b0; srt_sm_data = '0; srt_done = 1'b0;
    m_ld = 0; m_dly = 0; m_idx = -2;
    forever begin
      @(posedge clk); #2;
      if (srt_rst) begin
        m_ld = 0; m_dly = 0; m_idx = -2;
        srt_sm_valid = 1'b0; srt_sm_data = '0; srt_done = 1'b0;
      end else begin
        if (srt_um_valid && m_ld < 16) begin
          m_mem[m_ld] = srt_um_data;
          m_ld++;
          if (m_ld == 16) begin
            for (int i = 0; i < 15; i++)
              for (int j = 0; j < 15 - i; j++)
                if (m_mem[j] > m_mem[j+1]) begin
                  logic [7:0] t;
                  t = m_mem[j]; m_mem[j] = m_mem[j+1]; m_mem[j+1] = t;
                end
            m_dly = 3;
          end
        end else if (m_dly > 0) begin
          m_dly--;
          if (m_dly == 0) m_idx = -1;
        end else if (m_idx >= -1 && m_idx < 16) begin
          m_idx++;
        end
        if (m_idx >= -1 && m_idx < 16) begin
          srt_sm_valid = 1'b1; srt_done = 1'b0;
          srt_sm_data  = m_mem[(m_idx < 0) ? 0 : m_idx];
        end else if (m_idx >= 16) begin
          srt_sm_valid = 1'b0; srt_done = 1'b1;
        end else begin
          srt_sm_valid = 1'b0;
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({srt_rst, busy, req0_ready, req1_ready, srt_um_valid, res_valid, res_last, res_id} !== 8'b1000_0000) begin
      n_err++;
      $display("FAIL reset_outputs: got %b exp 10000000",
               {srt_rst, busy, req0_ready, req1_ready, srt_um_valid, res_valid, res_last, res_id});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || srt_rst !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset_idle: busy=%b srt_rst=%b exp busy=0 srt_rst=1", busy, srt_rst);
    end
    @(posedge clk); #1;
  endtask

  // Runs one job: who is the expected winner (with tie, both requesters raise
  // valid until the grant). abort_at > 0 asserts rst after that many result beats.
  task automatic do_job(input string name, input bit who, input bit tie, input bit stall,
                        input vec_t din, input vec_t dexp, input int abort_at);
    int k, beat, um_cnt, um_runs;
    bit granted, done, prev_um, other_bad;
    logic v, w_rdy, o_rdy;
    k = 0; beat = 0; um_cnt = 0; um_runs = 0;
    granted = 0; done = 0; prev_um = 0; other_bad = 0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      v = (k < 16) && !(stall && granted && (cyc % 2 == 1));
      if (who) begin
        req1_valid = v; req1_data = din[(k < 16) ? k : 15];
        req0_valid = tie && !granted; req0_data = din[0];
      end else begin
        req0_valid = v; req0_data = din[(k < 16) ? k : 15];
        req1_valid = tie && !granted; req1_data = din[0];
      end
      @(negedge clk);
      w_rdy = who ? req1_ready : req0_ready;
      o_rdy = who ? req0_ready : req1_ready;
      if (!granted && (req0_ready || req1_ready)) begin
        granted = 1;
        n_vec++;
        if (w_rdy !== 1'b1 || o_rdy !== 1'b0) begin
          n_err++;
          $display("FAIL %s grant: ready0=%b ready1=%b exp winner req%0d", name, req0_ready, req1_ready, who);
        end
      end else if (o_rdy) begin
        other_bad = 1;
      end
      if (w_rdy && v) k++;
      if (srt_um_valid) begin
        n_vec++;
        if (um_cnt >= 16 || srt_um_data !== din[um_cnt % 16] || srt_rst !== 1'b0) begin
          n_err++;
          $display("FAIL %s burst beat %0d: data=%h srt_rst=%b exp data=%h srt_rst=0",
                   name, um_cnt, srt_um_data, srt_rst, din[um_cnt % 16]);
        end
        if (!prev_um) um_runs++;
        um_cnt++;
      end
      prev_um = srt_um_valid;
      if (res_valid) begin
        n_vec++;
        if (res_data !== dexp[beat] || res_id !== who || res_last !== (beat == 15)) begin
          n_err++;
          $display("FAIL %s result beat %0d: data=%h id=%b last=%b exp data=%h id=%b last=%b",
                   name, beat, res_data, res_id, res_last, dexp[beat], who, (beat == 15));
        end
        beat++;
        if (beat == abort_at) begin
          rst = 1'b1;
          #1;
          n_vec++;
          if (res_valid !== 1'b0 || srt_rst !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s abort: res_valid=%b srt_rst=%b busy=%b exp 0 1 0", name, res_valid, srt_rst, busy);
          end
          done = 1;
        end else if (beat == 16) begin
          done = 1;
        end
      end
      if (!done) begin @(posedge clk); #1; end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL %s timeout: %0d result beats, exp 16", name, beat);
    end
    n_vec++;
    if (um_cnt !== 16 || um_runs !== 1 || other_bad) begin
      n_err++;
      $display("FAIL %s load stream: beats=%0d runs=%0d other_ready=%b exp 16 1 0", name, um_cnt, um_runs, other_bad);
    end
    if (abort_at > 0) begin
      @(posedge clk); #1;
      rst = 1'b0;
    end else begin
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b0 || srt_rst !== 1'b1 || res_valid !== 1'b0) begin
        n_err++;
        $display("FAIL %s return_idle: busy=%b srt_rst=%b res_valid=%b exp 0 1 0", name, busy, srt_rst, res_valid);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_round_robin();
    do_job("rr_job1", 1'b0, 1'b1, 1'b0, v_a, s_a, 0);
    do_job("rr_job2", 1'b1, 1'b1, 1'b0, v_b, s_b, 0);
    do_job("rr_job3", 1'b0, 1'b1, 1'b0, v_a, s_a, 0);
  endtask

  task automatic test_single_job();
    do_job("single", 1'b0, 1'b0, 1'b0, v_a, s_a, 0);
  endtask

  task automatic test_stall_collect();
    do_job("stall", 1'b1, 1'b0, 1'b1, v_b, s_b, 0);
  endtask

  task automatic test_all_equal();
    do_job("all_ff", 1'b0, 1'b0, 1'b0, v_f, v_f, 0);
  endtask

  task automatic test_rst_mid_drain();
    do_job("abort", 1'b0, 1'b0, 1'b0, v_a, s_a, 8);
    do_job("after_abort", 1'b0, 1'b1, 1'b0, v_b, s_b, 0);
  endtask

  // Job A from req0; req1 raises valid once A's burst starts.
  task automatic test_back_to_back();
    int ka, kb, um_cnt, beat, jobs, last_cyc, burst2_cyc;
    bit b_on, rdy_drain, prev_um, done;
    ka = 0; kb = 0; um_cnt = 0; beat = 0; jobs = 0; last_cyc = -100; burst2_cyc = 0;
    b_on = 0; rdy_drain = 0; prev_um = 0; done = 0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      req0_valid = (ka < 16); req0_data = v_a[(ka < 16) ? ka : 15];
      req1_valid = b_on && (kb < 16); req1_data = v_b[(kb < 16) ? kb : 15];
      @(negedge clk);
      if (req0_valid && req0_ready) ka++;
      if (req1_valid && req1_ready) kb++;
      if (srt_um_valid) begin
        b_on = 1;
        if (!prev_um && jobs == 1) burst2_cyc = cyc;
        n_vec++;
        if (srt_um_data !== ((um_cnt < 16) ? v_a[um_cnt % 16] : v_b[um_cnt % 16])) begin
          n_err++;
          $display("FAIL b2b burst beat %0d: got %h", um_cnt, srt_um_data);
        end
        um_cnt++;
      end
      prev_um = srt_um_valid;
      if (res_valid) begin
        if (jobs == 0 && req1_ready) rdy_drain = 1;
        n_vec++;
        if (res_data !== ((jobs == 0) ? s_a[beat] : s_b[beat]) || res_id !== jobs[0] || res_last !== (beat == 15)) begin
          n_err++;
          $display("FAIL b2b job%0d beat %0d: data=%h id=%b last=%b exp data=%h id=%b last=%b", jobs, beat,
                   res_data, res_id, res_last, (jobs == 0) ? s_a[beat] : s_b[beat], jobs[0], (beat == 15));
        end
        beat++;
        if (beat == 16) begin
          beat = 0;
          if (jobs == 0) last_cyc = cyc;
          jobs++;
          if (jobs == 2) done = 1;
        end
      end
      if (!done) begin @(posedge clk); #1; end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL b2b timeout: jobs=%0d exp 2", jobs);
    end
    n_vec++;
    if (rdy_drain !== EXP_RDY_DRAIN) begin
      n_err++;
      $display("FAIL b2b ready_in_drain: got %b exp %b", rdy_drain, EXP_RDY_DRAIN);
    end
    n_vec++;
    if (burst2_cyc - last_cyc !== EXP_GAP) begin
      n_err++;
      $display("FAIL b2b burst_gap: got %0d exp %0d", burst2_cyc - last_cyc, EXP_GAP);
    end
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b return_idle: busy=%b exp 0", busy);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_job();
    test_stall_collect();
    test_all_equal();
    test_rst_mid_drain();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sort_arb.md
SORT_ARB -- requirements
Module: sort_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, element width.
REQ-002 SHALL have parameter ELEMENT_NUM, default 16, elements per sort job.
REQ-003 SHALL have parameter LOG2_ELEMENT_NUM, default 4, index width.
REQ-004 SHALL have port clk  in  1  single clock for all logic.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports req0_valid/req1_valid  in  1 each  requester element valid.
REQ-007 SHALL have ports req0_data/req1_data  in  DATA_WIDTH each  requester element.
REQ-008 SHALL have ports req0_ready/req1_ready  out  1 each  element accepted when valid&ready.
REQ-009 SHALL have port srt_rst  out  1  reset to the sorter core.
REQ-010 SHALL have ports srt_um_valid  out  1  and srt_um_data  out  DATA_WIDTH  sorter load stream.
REQ-011 SHALL have ports srt_sm_valid  in  1, srt_sm_data  in  DATA_WIDTH, srt_done  in  1  sorter output side.
REQ-012 SHALL have ports res_valid  out  1, res_data  out  DATA_WIDTH, res_id  out  1, res_last  out  1  sorted result stream, no backpressure.
REQ-013 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-014 SHALL implement states IDLE, COLLECT, BURST, SORT, DRAIN.
REQ-015 IDLE: SHALL grant round-robin among requesters with valid high; requester not served last wins a tie; after reset requester 0 wins a tie; grant registered, then COLLECT.
REQ-016 COLLECT: SHALL assert ready only to the granted requester, store exactly ELEMENT_NUM accepted beats into a local staging buffer at index 0..ELEMENT_NUM-1; stalls permitted; on Nth beat go to BURST.
REQ-017 srt_rst SHALL be 1 in IDLE and COLLECT and 0 in BURST, SORT, DRAIN.
REQ-018 BURST: SHALL drive srt_um_valid=1 for exactly ELEMENT_NUM consecutive cycles with srt_um_data=buffer[k] in cycle k, starting the first cycle srt_rst is 0; srt_um_valid SHALL be 0 the cycle after, then SORT.
REQ-019 SORT: SHALL wait for srt_sm_valid=1, then DRAIN in that same cycle's decision.
REQ-020 DRAIN: res_valid SHALL equal srt_sm_valid & ~srt_done, res_data=srt_sm_data, res_id=granted requester, combinational pass-through (zero latency).
REQ-021 res_last SHALL be 1 on the ELEMENT_NUM-th res_valid beat of a job; next cycle SHALL return to IDLE.
REQ-022 Exactly ELEMENT_NUM res_valid beats SHALL be emitted per job, in sorter output order.
REQ-023 req*_ready SHALL be 0 outside COLLECT (unless REQ-028); requester grant SHALL not change within a job.
REQ-024 Load counter and drain counter SHALL be LOG2_ELEMENT_NUM+1 bits, cleared on each state entry; no wrap within a job.

Reset
REQ-025 On rst, asynchronously: state=IDLE, srt_rst=1, all ready/valid outputs 0, res_last=0, res_id=0, busy=0, round-robin pointer favours requester 0, staging buffer contents and counters discarded.
REQ-026 rst mid-job SHALL abort the job with no further res_valid beats; partially collected elements are lost.

Configuration
REQ-027 Macro SORT_ARB_PREFETCH_EN SHALL select overlap of collection with sorting.
REQ-028 With it: during SORT and DRAIN, next job SHALL be granted and collected into the staging buffer; from DRAIN end, with buffer full, SHALL spend one cycle with srt_rst=1 then enter BURST; partial buffer resumes in COLLECT.
REQ-029 Without it: req*_ready strictly 0 outside COLLECT; no collection overlaps SORT/DRAIN.

Verification
REQ-030 Single job, req0 sends 16 elements 5,3,…, no stalls -> 16 res_valid beats, res_id=0, res_last on 16th, back to IDLE, srt_rst=1.
REQ-031 Both requesters valid from reset -> req0 served first, then req1; third job goes to req0.
REQ-032 req1 valid deasserted every other cycle during COLLECT -> srt_um_valid still exactly 16 contiguous cycles.
REQ-033 rst asserted on 8th DRAIN beat -> res_valid 0 immediately, srt_rst=1, state IDLE, next job correct.
REQ-034 With SORT_ARB_PREFETCH_EN, back-to-back jobs -> req ready high during DRAIN, next BURST starts 2 cycles after res_last; without macro, ready 0 during DRAIN.
REQ-035 All-equal elements 0xFF -> 16 beats of 0xFF, res_last on 16th.
